i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h40, is the 7-bit target address sent in every address byte.
REQ-002 Parameter HALF_PERIOD, default 4, is the number of clk cycles per SCL half-period; the legal range is 2 to 255.
REQ-003 clk  input  1  is the single clock, the 400 kHz oscillator domain.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 cmd_valid  input  1  means a command request is present.
REQ-006 cmd_ready  output  1  means the block can accept a command; it is high only in IDLE.
REQ-007 cmd_rw  input  1  selects the operation: 0 = register write, 1 = register read.
REQ-008 cmd_addr  input  3  is the register address (0x0–0x7).
REQ-009 cmd_wdata  input  8  is the write data.
REQ-010 rsp_valid  output  1  is a one-cycle completion pulse.
REQ-011 rsp_rdata  output  8  is the read data, valid with rsp_valid.
REQ-012 rsp_nack  output  1  means the transaction was aborted on a NACK; it is valid with rsp_valid.
REQ-013 busy  output  1  means a transaction is in progress, from command accept through rsp_valid.
REQ-014 scl  output  1  is the I2C clock, driven push-pull; the idle level is 1.
REQ-015 sda  inout  1  is the I2C data line, open-drain: the block drives only 1'b0 or 1'bz.

Function
REQ-016 A command is accepted on the cycle where cmd_valid && cmd_ready; cmd_rw, cmd_addr and cmd_wdata are captured on that cycle, and cmd_valid is ignored in every other state.
REQ-017 The states are IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP and DONE.
REQ-018 The write sequence is START, {DEVICE_ADDR,0}, ACK, {5'b0,cmd_addr}, ACK, cmd_wdata, ACK, STOP.
REQ-019 The read sequence is START, {DEVICE_ADDR,0}, ACK, {5'b0,cmd_addr}, ACK, repeated START, {DEVICE_ADDR,1}, ACK, 8 data bits, master NACK, STOP.
REQ-020 Bytes are sent MSB first.
REQ-021 SDA changes only on the first clk of an SCL-low half.
REQ-022 SDA is sampled on the last clk of an SCL-high half.
REQ-023 START and repeated START are SDA falling while SCL is high, held for HALF_PERIOD cycles before SCL falls.
REQ-024 STOP is SDA rising while SCL is high, HALF_PERIOD cycles after SCL rises.
REQ-025 In RX_ACK, a sampled SDA of 0 is ACK; a sampled SDA of 1 is NACK, which goes to STOP, then DONE with rsp_nack=1 and rsp_rdata=8'h00.
REQ-026 In RX_BYTE, sda is released and the 8 sampled bits shift into rsp_rdata MSB first.
REQ-027 For writes, rsp_rdata is 8'h00.
REQ-028 DONE asserts rsp_valid for exactly one clk, then returns to IDLE, where cmd_ready is 1 on the next cycle.
REQ-029 A bit counter wraps 7→0 per byte, and a half-period counter reloads at HALF_PERIOD-1.
REQ-030 The block performs no clock stretching detection; scl is never read back.

Reset
REQ-031 While reset is high: state=IDLE, scl=1, sda released (z), cmd_ready=0, rsp_valid=0, rsp_nack=0, rsp_rdata=8'h00, busy=0, and all counters are 0.
REQ-032 Reset asserted mid-transaction aborts immediately with no STOP generated and no rsp_valid.
REQ-033 cmd_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-034 With I2C_MASTER_RETRY_EN defined, a NACK on the first address byte causes STOP, then a full restart of the same transaction, up to 2 retries (3 attempts total); rsp_nack=1 only if the final attempt NACKs, and a data-phase NACK never retries.
REQ-035 Without I2C_MASTER_RETRY_EN, any NACK reports rsp_nack=1 after the first attempt.

Verification
REQ-036 Write: cmd_rw=0, addr=3, wdata=8'hA5, slave model ACKs -> bytes 8'h80, 8'h03, 8'hA5 appear on the wire, then STOP, rsp_valid=1, rsp_nack=0.
REQ-037 Read: cmd_rw=1, addr=5, slave returns 8'h3C -> bytes 8'h80, 8'h05, repeated START, 8'h81 on the wire, master NACKs, rsp_rdata=8'h3C, rsp_nack=0.
REQ-038 Address NACK, macro off: no device at 7'h40 -> exactly one address byte, STOP, rsp_nack=1, rsp_rdata=8'h00.
REQ-039 Address NACK, macro on: device ACKs on the 3rd attempt -> 3 START conditions on the wire, rsp_nack=0.
REQ-040 Reset mid-byte: reset pulsed during the bit-4 transmit of the data byte -> next cycle scl=1, sda=z, no rsp_valid, and cmd_ready=1 after reset deasserts.
REQ-041 Back-to-back commands with cmd_valid held high, HALF_PERIOD=2 -> the second command is accepted exactly 1 cycle after the first rsp_valid, and SCL high/low halves each measure 2 clk.

Source files
------------

// File: rtl/i2c_master_if.sv
// Command/response bus between a requester and i2c_master.
interface i2c_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy
  );
endinterface

// File: rtl/i2c_master.sv
// Single-target I2C master performing one register write or read per command.
// Define I2C_MASTER_RETRY_EN to retry a NACKed first address byte up to twice.
module i2c_master #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h40,
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic         clk,
  input  logic         reset,
  i2c_master_if.slave  bus,
  output logic         scl,
  inout  wire          sda
);
  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE
  } state_t;

  localparam logic [7:0] HMAX = 8'(HALF_PERIOD - 1);

  state_t     state, state_n;
  logic [7:0] hcnt, hcnt_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [1:0] byte_idx, byte_idx_n;
  logic       rw, rw_n;
  logic [2:0] addr, addr_n;
  logic [7:0] wdata, wdata_n;
  logic [7:0] rdata, rdata_n;
  logic       nack, nack_n;
  logic       scl_c, sda_low, hdone, sda_in;
  logic [7:0] tx_byte;
`ifdef I2C_MASTER_RETRY_EN
  logic       again, again_n;
  logic [1:0] retries, retries_n;
`endif

  assign hdone  = (hcnt == '0);
  assign sda_in = sda;

  always_comb begin
    unique case (byte_idx)
      2'd0:    tx_byte = {DEVICE_ADDR, 1'b0};
      2'd1:    tx_byte = {5'b0, addr};
      default: tx_byte = rw ? {DEVICE_ADDR, 1'b1} : wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      phase    <= '0;
      bitcnt   <= '0;
      byte_idx <= '0;
      rw       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      nack     <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
      again    <= 1'b0;
      retries  <= '0;
`endif
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      phase    <= phase_n;
      bitcnt   <= bitcnt_n;
      byte_idx <= byte_idx_n;
      rw       <= rw_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      rdata    <= rdata_n;
      nack     <= nack_n;
`ifdef I2C_MASTER_RETRY_EN
      again    <= again_n;
      retries  <= retries_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bitcnt_n   = bitcnt;
    byte_idx_n = byte_idx;
    rw_n       = rw;
    addr_n     = addr;
    wdata_n    = wdata;
    rdata_n    = rdata;
    nack_n     = nack;
`ifdef I2C_MASTER_RETRY_EN
    again_n    = again;
    retries_n  = retries;
`endif
    scl_c      = 1'b1;
    sda_low    = 1'b0;
    if (state == IDLE || state == DONE) hcnt_n = '0;
    else if (hdone)                     hcnt_n = HMAX;
    else                                hcnt_n = hcnt - 8'd1;

    // Bit-level states: phase[0]=0 is the SCL-low half, 1 the SCL-high half.
    unique case (state)
      IDLE: if (bus.cmd_valid) begin
        rw_n       = bus.cmd_rw;
        addr_n     = bus.cmd_addr;
        wdata_n    = bus.cmd_wdata;
        rdata_n    = '0;
        nack_n     = 1'b0;
        byte_idx_n = '0;
        phase_n    = '0;
        bitcnt_n   = '0;
        hcnt_n     = HMAX;
`ifdef I2C_MASTER_RETRY_EN
        retries_n  = '0;
`endif
        state_n    = START;
      end
      START: begin
        sda_low = 1'b1;
        if (hdone) begin
          phase_n  = '0;
          bitcnt_n = '0;
          state_n  = TX_BYTE;
        end
      end
      TX_BYTE: begin
        scl_c   = phase[0];
        sda_low = ~tx_byte[~bitcnt];
        if (hdone) begin
          if (!phase[0]) phase_n = 2'd1;
          else begin
            phase_n  = '0;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_n = RX_ACK;
          end
        end
      end
      RX_ACK: begin
        scl_c = phase[0];
        if (hdone) begin
          if (!phase[0]) phase_n = 2'd1;
          else begin
            phase_n = '0;
            if (sda_in) begin
              state_n = STOP;
`ifdef I2C_MASTER_RETRY_EN
              if (byte_idx == 2'd0 && retries != 2'd2) begin
                again_n   = 1'b1;
                retries_n = retries + 2'd1;
              end else nack_n = 1'b1;
`else
              nack_n = 1'b1;
`endif
            end else if (byte_idx == 2'd0) begin
              byte_idx_n = 2'd1;
              state_n    = TX_BYTE;
            end else if (byte_idx == 2'd1) begin
              if (rw) state_n = RESTART;
              else begin
                byte_idx_n = 2'd2;
                state_n    = TX_BYTE;
              end
            end else begin
              state_n = rw ? RX_BYTE : STOP;
            end
          end
        end
      end
      RESTART: begin
        // low/released, high/released, then SDA falls with SCL still high
        scl_c   = (phase != 2'd0);
        sda_low = (phase == 2'd2);
        if (hdone) begin
          if (phase != 2'd2) phase_n = phase + 2'd1;
          else begin
            phase_n    = '0;
            bitcnt_n   = '0;
            byte_idx_n = 2'd2;
            state_n    = TX_BYTE;
          end
        end
      end
      RX_BYTE: begin
        scl_c = phase[0];
        if (hdone) begin
          if (!phase[0]) phase_n = 2'd1;
          else begin
            phase_n  = '0;
            rdata_n  = {rdata[6:0], sda_in};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_n = TX_NACK;
          end
        end
      end
      TX_NACK: begin
        scl_c = phase[0];
        if (hdone) begin
          if (!phase[0]) phase_n = 2'd1;
          else begin
            phase_n = '0;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        // third half keeps the bus free before DONE or a retry START
        scl_c   = (phase != 2'd0);
        sda_low = (phase != 2'd2);
        if (hdone) begin
          if (phase != 2'd2) phase_n = phase + 2'd1;
          else begin
            phase_n = '0;
            state_n = DONE;
`ifdef I2C_MASTER_RETRY_EN
            if (again) begin
              again_n    = 1'b0;
              byte_idx_n = '0;
              state_n    = START;
            end
`endif
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == DONE) && !reset;
  assign bus.busy      = (state != IDLE) && !reset;
  assign bus.rsp_rdata = reset ? '0 : rdata;
  assign bus.rsp_nack  = nack && !reset;
  assign scl           = reset | scl_c;
  assign sda           = (sda_low && !reset) ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: wire-level slave model plus transaction-level expectations.
module tb_i2c_master;
  localparam int HP = 2;
`ifdef I2C_MASTER_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl;
  wire  sda;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  i2c_master_if bus ();

  i2c_master #(.DEVICE_ADDR(7'h40), .HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave model / wire monitor (samples on the falling clk edge)
  logic       slave_low = 1'b0;
  logic [7:0] slave_rdata = 8'h00;
  int         naks_cfg = 0, naks_base = 0, nak_byte_no = -1;
  logic [7:0] wire_bytes[$];
  int         starts = 0, stops = 0, addr_bytes_seen = 0;
  int         bit_i = 0, byte_no = 0;
  logic       reading = 1'b0, master_ack = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         run_len = 0, lo_runs = 0, lo_bad = 0, hi_runs = 0, hi_bad = 0;
  logic       run_valid = 1'b0, run_has_start = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic s_hi, d_hi, ack;
    s_hi = (scl === 1'b1);
    d_hi = (sda !== 1'b0);
    if (reset) begin
      run_valid = 1'b0;
      slave_low = 1'b0;
    end
    if (s_hi == p_scl) run_len++;
    else begin
      if (run_valid && !p_scl) begin
        lo_runs++;
        if (run_len != HP) lo_bad++;
      end else if (run_valid && !run_has_start) begin
        hi_runs++;
        if (run_len != HP) hi_bad++;
      end
      run_len = 1;
      run_valid = !reset;
      run_has_start = 1'b0;
    end
    if (p_scl && s_hi && p_sda && !d_hi) begin
      starts++;
      bit_i = 0;
      byte_no = 0;
      reading = 1'b0;
      run_has_start = 1'b1;
    end else if (p_scl && s_hi && !p_sda && d_hi) begin
      stops++;
      slave_low = 1'b0;
    end
    if (!p_scl && s_hi) begin
      if (bit_i < 8) begin
        shreg = {shreg[6:0], d_hi};
        bit_i++;
        if (bit_i == 8) begin
          if (byte_no == 0) reading = shreg[0];
          if (!(reading && byte_no > 0)) wire_bytes.push_back(shreg);
        end
      end else begin
        if (reading && byte_no == 1) master_ack = d_hi;
        bit_i = 0;
        byte_no++;
      end
    end
    if (p_scl && !s_hi && !reset) begin
      slave_low = 1'b0;
      if (bit_i == 8 && !(reading && byte_no > 0)) begin
        if (byte_no == 0) begin
          ack = (shreg[7:1] == 7'h40) && ((addr_bytes_seen - naks_base) >= naks_cfg);
          addr_bytes_seen++;
        end else ack = (byte_no != nak_byte_no);
        slave_low = ack;
      end else if (bit_i < 8 && reading && byte_no == 1) begin
        slave_low = !slave_rdata[7 - bit_i];
      end
    end
    p_scl = s_hi;
    p_sda = d_hi;
  end

  task automatic run_cmd(input logic rw, input logic [2:0] a, input logic [7:0] wd,
                         output logic [7:0] rd, output logic nk, output logic bsy,
                         output logic tmo);
    int k;
    tmo = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid && k < 5000);
    if (!bus.rsp_valid) tmo = 1'b1;
    rd  = bus.rsp_rdata;
    nk  = bus.rsp_nack;
    bsy = bus.busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (scl !== 1'b1) begin n_err++; $display("FAIL rst_scl: got %b expected 1", scl); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda: got %b expected released(1)", sda); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", bus.cmd_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_nack !== 1'b0)
      begin n_err++; $display("FAIL rst_flags: got v%b b%b n%b expected all 0", bus.rsp_valid, bus.busy, bus.rsp_nack); end
    n_cmp++; if (bus.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h expected 00", bus.rsp_rdata); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_write;
    logic [7:0] rd, wd, exp[$];
    logic [2:0] a;
    logic nk, bsy, tmo;
    int wb0, s0, p0;
    for (int t = 0; t < 5; t++) begin
      a  = (t == 0) ? 3'd3 : 3'($urandom_range(7));
      wd = (t == 0) ? 8'hA5 : 8'($urandom);
      exp = '{8'h80, {5'b0, a}, wd};
      wb0 = wire_bytes.size(); s0 = starts; p0 = stops;
      run_cmd(1'b0, a, wd, rd, nk, bsy, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL wr_timeout: got no rsp_valid expected rsp_valid"); end
      n_cmp++; if (wire_bytes.size() - wb0 != exp.size())
        begin n_err++; $display("FAIL wr_nbytes: got %0d expected %0d", wire_bytes.size() - wb0, exp.size()); end
      else foreach (exp[i]) begin
        n_cmp++; if (wire_bytes[wb0+i] !== exp[i])
          begin n_err++; $display("FAIL wr_byte%0d: got %h expected %h", i, wire_bytes[wb0+i], exp[i]); end
      end
      n_cmp++; if (starts - s0 != 1 || stops - p0 != 1)
        begin n_err++; $display("FAIL wr_start_stop: got %0d/%0d expected 1/1", starts - s0, stops - p0); end
      n_cmp++; if (nk !== 1'b0 || rd !== 8'h00 || bsy !== 1'b1)
        begin n_err++; $display("FAIL wr_rsp: got nack %b rdata %h busy %b expected 0 00 1", nk, rd, bsy); end
    end
  endtask

  task automatic test_read;
    logic [7:0] rd, sd, exp[$];
    logic [2:0] a;
    logic nk, bsy, tmo;
    int wb0, s0, p0;
    for (int t = 0; t < 5; t++) begin
      a  = (t == 0) ? 3'd5 : 3'($urandom_range(7));
      sd = (t == 0) ? 8'h3C : 8'($urandom);
      slave_rdata = sd;
      exp = '{8'h80, {5'b0, a}, 8'h81};
      wb0 = wire_bytes.size(); s0 = starts; p0 = stops;
      run_cmd(1'b1, a, 8'h00, rd, nk, bsy, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL rd_timeout: got no rsp_valid expected rsp_valid"); end
      n_cmp++; if (wire_bytes.size() - wb0 != exp.size())
        begin n_err++; $display("FAIL rd_nbytes: got %0d expected %0d", wire_bytes.size() - wb0, exp.size()); end
      else foreach (exp[i]) begin
        n_cmp++; if (wire_bytes[wb0+i] !== exp[i])
          begin n_err++; $display("FAIL rd_byte%0d: got %h expected %h", i, wire_bytes[wb0+i], exp[i]); end
      end
      n_cmp++; if (starts - s0 != 2 || stops - p0 != 1)
        begin n_err++; $display("FAIL rd_start_stop: got %0d/%0d expected 2/1", starts - s0, stops - p0); end
      n_cmp++; if (rd !== sd) begin n_err++; $display("FAIL rd_data: got %h expected %h", rd, sd); end
      n_cmp++; if (nk !== 1'b0 || master_ack !== 1'b1)
        begin n_err++; $display("FAIL rd_nack: got rsp_nack %b master_ack %b expected 0 1", nk, master_ack); end
    end
  endtask

  task automatic test_nack;
    int cfg_naks[3] = '{100, 2, 0};
    int cfg_byte[3] = '{-1, -1, 1};
    logic [7:0] rd, wd, exp[$];
    logic [2:0] a;
    logic nk, bsy, tmo, ok;
    int wb0, s0, p0, att;
    for (int t = 0; t < 3; t++) begin
      a  = 3'($urandom_range(7));
      wd = 8'($urandom);
      // attempt count from the retry rule; data-phase NACK never retries
      att = (cfg_naks[t] + 1 < ATTEMPTS) ? cfg_naks[t] + 1 : ATTEMPTS;
      ok  = (cfg_naks[t] < ATTEMPTS);
      exp = {};
      for (int i = 0; i < att; i++) exp.push_back(8'h80);
      if (ok) exp.push_back({5'b0, a});
      if (ok && cfg_byte[t] != 1) exp.push_back(wd);
      naks_cfg = cfg_naks[t];
      nak_byte_no = cfg_byte[t];
      naks_base = addr_bytes_seen;
      wb0 = wire_bytes.size(); s0 = starts; p0 = stops;
      run_cmd(1'b0, a, wd, rd, nk, bsy, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL nk%0d_timeout: got no rsp_valid expected rsp_valid", t); end
      n_cmp++; if (wire_bytes.size() - wb0 != exp.size())
        begin n_err++; $display("FAIL nk%0d_nbytes: got %0d expected %0d", t, wire_bytes.size() - wb0, exp.size()); end
      else foreach (exp[i]) begin
        n_cmp++; if (wire_bytes[wb0+i] !== exp[i])
          begin n_err++; $display("FAIL nk%0d_byte%0d: got %h expected %h", t, i, wire_bytes[wb0+i], exp[i]); end
      end
      n_cmp++; if (starts - s0 != att || stops - p0 != att)
        begin n_err++; $display("FAIL nk%0d_start_stop: got %0d/%0d expected %0d/%0d", t, starts - s0, stops - p0, att, att); end
      n_cmp++; if (nk !== !(ok && cfg_byte[t] != 1) || rd !== 8'h00)
        begin n_err++; $display("FAIL nk%0d_rsp: got nack %b rdata %h expected %b 00", t, nk, rd, !(ok && cfg_byte[t] != 1)); end
    end
    naks_cfg = 0;
    nak_byte_no = -1;
  endtask

  task automatic test_reset_mid_byte;
    int wb0, k, seen;
    wb0 = wire_bytes.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = 3'd6;
    bus.cmd_wdata = 8'h5A;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    k = 0;
    while (!(wire_bytes.size() == wb0 + 2 && byte_no == 2 && bit_i == 4) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k >= 2000) begin n_err++; $display("FAIL mid_reach_bit4: got timeout expected data bit 4"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (scl !== 1'b1 || sda !== 1'b1)
      begin n_err++; $display("FAIL mid_bus: got scl %b sda %b expected 1 released(1)", scl, sda); end
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0)
      begin n_err++; $display("FAIL mid_flags: got v%b b%b r%b expected 0 0 0", bus.rsp_valid, bus.busy, bus.cmd_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b expected 1", bus.cmd_ready); end
    seen = 0;
    repeat (60) begin
      if (bus.rsp_valid === 1'b1 || scl !== 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_quiet: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    int acc[$], rsp[$];
    int lr0, lb0, hr0, hb0;
    lr0 = lo_runs; lb0 = lo_bad; hr0 = hi_runs; hb0 = hi_bad;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = 3'($urandom_range(7));
    bus.cmd_wdata = 8'($urandom);
    for (int k = 0; k < 3000 && rsp.size() < 2; k++) begin
      if (bus.cmd_valid && bus.cmd_ready) acc.push_back(cyc);
      if (bus.rsp_valid) begin
        rsp.push_back(cyc);
        if (rsp.size() == 2) bus.cmd_valid = 1'b0;
      end
      if (rsp.size() < 2) @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    n_cmp++; if (acc.size() != 2 || rsp.size() != 2)
      begin n_err++; $display("FAIL b2b_count: got %0d acc %0d rsp expected 2 2", acc.size(), rsp.size()); end
    else begin
      n_cmp++; if (acc[1] != rsp[0] + 1)
        begin n_err++; $display("FAIL b2b_gap: got accept at %0d expected %0d", acc[1], rsp[0] + 1); end
    end
    n_cmp++; if (lo_runs == lr0 || lo_bad != lb0)
      begin n_err++; $display("FAIL b2b_scl_low: got %0d bad of %0d halves expected 0 bad of >0", lo_bad - lb0, lo_runs - lr0); end
    n_cmp++; if (hi_runs == hr0 || hi_bad != hb0)
      begin n_err++; $display("FAIL b2b_scl_high: got %0d bad of %0d halves expected 0 bad of >0", hi_bad - hb0, hi_runs - hr0); end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nack;
    test_reset_mid_byte;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
